// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared types, limits and helpers for the multi-channel clock divider.
//   CLKDIV_MAX_NCH  upper bound on the number of divider channels
//   CLKDIV_HALF_W   container width of the per-channel half/pend_val registers;
//                   every configured CNT_W must not exceed it
//   clkdiv_half()   HALF value that turns f_in into f_out (f_in / (2*f_out) - 1)
//   clkdiv_cfg_t    per-channel configuration state {half, pend_val, pend}
package clkdiv_pkg;

    localparam int unsigned CLKDIV_MAX_NCH = 16;
    localparam int unsigned CLKDIV_HALF_W  = 32;

    typedef struct packed {
        logic [CLKDIV_HALF_W-1:0] half;
        logic [CLKDIV_HALF_W-1:0] pend_val;
        logic                     pend;
    } clkdiv_cfg_t;

    function automatic int unsigned clkdiv_half(input int unsigned f_in, input int unsigned f_out);
        return f_in / (2 * f_out) - 1;
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// clkdiv_channel: one divider channel producing a 50% duty square wave of
// period 2*(half+1) clk_in cycles.
// Optional feature macro: CLKDIV_TICK_EN (registered one-cycle tick on each
// rising toggle of clk_out; when undefined tick is tied low and has no flop).
// Ports:
//   clk_in   divider input clock
//   rst      asynchronous active-high reset
//   en       channel enable; low forces cnt=0, clk_out=0 and applies any pending HALF
//   wr       single-cycle write strobe for this channel
//   wr_half  HALF value captured when wr is high
//   clk_out  divided clock
//   tick     rising-toggle pulse (CLKDIV_TICK_EN only, else 0)
//   pend     a written HALF is waiting for the next toggle boundary
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int unsigned      CNT_W    = 16,
    parameter logic [CNT_W-1:0] DEF_HALF = CNT_W'(499)
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_half,
    output logic             clk_out,
    output logic             tick,
    output logic             pend
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    clkdiv_cfg_t      cfg_q, cfg_d;
    logic             out_q, out_d;
    logic             hit;

    // >= rather than == so a counter that is somehow past half still terminates.
    assign hit = CLKDIV_HALF_W'(cnt_q) >= cfg_q.half;

    always_comb begin
        cnt_d = cnt_q;
        cfg_d = cfg_q;
        out_d = out_q;
        if (!en) begin
            cnt_d = '0;
            out_d = 1'b0;
            if (cfg_q.pend) begin
                cfg_d.half = cfg_q.pend_val;
                cfg_d.pend = 1'b0;
            end
        end else if (hit) begin
            cnt_d = '0;
            out_d = ~out_q;
            if (cfg_q.pend) begin
                cfg_d.half = cfg_q.pend_val;
                cfg_d.pend = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // A write on the same edge as an apply lands after it: the old pending
        // value is consumed and the new one waits for the next boundary.
        if (wr) begin
            cfg_d.pend_val = CLKDIV_HALF_W'(wr_half);
            cfg_d.pend     = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            cfg_q <= '{half: CLKDIV_HALF_W'(DEF_HALF), pend_val: '0, pend: 1'b0};
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            cfg_q <= cfg_d;
            out_q <= out_d;
        end
    end

`ifdef CLKDIV_TICK_EN
    logic tick_q, tick_d;

    // Only a counted 0->1 toggle ticks; a disable-forced drop never does.
    assign tick_d = en & hit & ~out_q;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
`else
    assign tick = 1'b0;
`endif

    assign clk_out = out_q;
    assign pend    = cfg_q.pend;

endmodule

// File: rtl/clock_divider_multi.sv
// clock_divider_multi: NCH independent programmable clock dividers, each giving
// f_in / (2*(HALF+1)) with 50% duty. HALF is loaded through a shared config bus
// and applied only at a toggle boundary (or immediately while disabled).
// Optional feature macro: CLKDIV_TICK_EN (per-channel rising-toggle tick pulse).
// Parameters: NCH (1..CLKDIV_MAX_NCH), CNT_W (<= CLKDIV_HALF_W), DEF_HALF.
// Ports:
//   clk_in    divider input clock
//   rst       asynchronous active-high reset
//   ch_en     per-channel enable
//   cfg_wr    single-cycle write strobe for a new HALF
//   cfg_ch    target channel of cfg_wr (values >= NCH are ignored)
//   cfg_half  new HALF value
//   cfg_pend  per-channel "written HALF not yet applied"
//   clk_out   divided clocks
//   tick      per-channel rising-toggle pulse (0 unless CLKDIV_TICK_EN)
module clock_divider_multi
    import clkdiv_pkg::*;
#(
    parameter int unsigned      NCH      = 4,
    parameter int unsigned      CNT_W    = 16,
    parameter logic [CNT_W-1:0] DEF_HALF = CNT_W'(clkdiv_half(1_000_000, 1_000)),
    localparam int unsigned     CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [NCH-1:0]   ch_en,
    input  logic             cfg_wr,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_half,
    output logic [NCH-1:0]   cfg_pend,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick
);

    logic [NCH-1:0] wr_stb;

    always_comb begin
        wr_stb = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (cfg_wr && (32'(cfg_ch) == i)) begin
                wr_stb[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        clkdiv_channel #(
            .CNT_W    (CNT_W),
            .DEF_HALF (DEF_HALF)
        ) u_ch (
            .clk_in   (clk_in),
            .rst      (rst),
            .en       (ch_en[g]),
            .wr       (wr_stb[g]),
            .wr_half  (cfg_half),
            .clk_out  (clk_out[g]),
            .tick     (tick[g]),
            .pend     (cfg_pend[g])
        );
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// tb_clock_divider_multi: directed bench for clock_divider_multi (NCH=4, CNT_W=16,
// DEF_HALF=499). A per-channel event-scheduling model predicts clk_out, cfg_pend
// and tick each cycle; literal checks pin the model at hand-computed points.
// Edge counts below are posedges since the last reset release.
module tb_clock_divider_multi;

    localparam int unsigned NCH      = 4;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned DEF_HALF = 499;
`ifdef CLKDIV_TICK_EN
    localparam logic TICK_ON = 1'b1;
`else
    localparam logic TICK_ON = 1'b0;
`endif

    logic             clk_in   = 1'b0;
    logic             rst      = 1'b1;
    logic [NCH-1:0]   ch_en    = '1;
    logic             cfg_wr   = 1'b0;
    logic [1:0]       cfg_ch   = '0;
    logic [CNT_W-1:0] cfg_half = '0;
    logic [NCH-1:0]   cfg_pend;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;

    int n_checks = 0;
    int n_fail   = 0;
    int edges    = 0;

    always #5 clk_in = ~clk_in;

    clock_divider_multi #(
        .NCH      (NCH),
        .CNT_W    (CNT_W),
        .DEF_HALF (16'(DEF_HALF))
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .ch_en    (ch_en),
        .cfg_wr   (cfg_wr),
        .cfg_ch   (cfg_ch),
        .cfg_half (cfg_half),
        .cfg_pend (cfg_pend),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    // Model: each channel remembers the absolute edge number of its next toggle.
    typedef struct {
        logic        out;
        logic        tick;
        logic        pend;
        int unsigned half;
        int unsigned pval;
        longint      next;
    } ch_model_t;

    ch_model_t m [NCH];
    longint    m_edge;

    function automatic ch_model_t ch_reset();
        ch_model_t r;
        r.out  = 1'b0;
        r.tick = 1'b0;
        r.pend = 1'b0;
        r.half = DEF_HALF;
        r.pval = 0;
        r.next = longint'(DEF_HALF);
        return r;
    endfunction

    function automatic ch_model_t ch_step(input ch_model_t s, input logic en, input logic wr,
                                          input int unsigned val, input longint e);
        ch_model_t r;
        r      = s;
        r.tick = 1'b0;
        if (!en) begin
            r.out = 1'b0;
            if (r.pend) begin
                r.half = r.pval;
                r.pend = 1'b0;
            end
            r.next = e + 1 + longint'(r.half);
        end else if (e == s.next) begin
            r.tick = !s.out;
            r.out  = !s.out;
            if (r.pend) begin
                r.half = r.pval;
                r.pend = 1'b0;
            end
            r.next = e + 1 + longint'(r.half);
        end
        if (wr) begin
            r.pval = val;
            r.pend = 1'b1;
        end
        return r;
    endfunction

    always @(posedge clk_in or posedge rst) begin
        if (rst) begin
            m_edge <= 0;
            for (int i = 0; i < NCH; i++) m[i] <= ch_reset();
        end else begin
            for (int i = 0; i < NCH; i++)
                m[i] <= ch_step(m[i], ch_en[i], cfg_wr && (32'(cfg_ch) == i), 32'(cfg_half), m_edge);
            m_edge <= m_edge + 1;
        end
    end

    function automatic logic [NCH-1:0] exp_out();
        logic [NCH-1:0] r;
        for (int i = 0; i < NCH; i++) r[i] = m[i].out;
        return r;
    endfunction

    function automatic logic [NCH-1:0] exp_pend();
        logic [NCH-1:0] r;
        for (int i = 0; i < NCH; i++) r[i] = m[i].pend;
        return r;
    endfunction

    function automatic logic [NCH-1:0] exp_tick();
        logic [NCH-1:0] r;
        for (int i = 0; i < NCH; i++) r[i] = m[i].tick & TICK_ON;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, edges, $time);
        end
    endtask

    always @(negedge clk_in) begin
        check("model_clk_out", 32'(clk_out), 32'(exp_out()));
        check("model_cfg_pend", 32'(cfg_pend), 32'(exp_pend()));
        check("model_tick", 32'(tick), 32'(exp_tick()));
    end

    task automatic run_to(input int target);
        while (edges < target) begin
            @(negedge clk_in);
            edges++;
        end
    endtask

    task automatic write_cfg(input logic [1:0] ch, input logic [CNT_W-1:0] val);
        cfg_wr   = 1'b1;
        cfg_ch   = ch;
        cfg_half = val;
        run_to(edges + 1);
        cfg_wr   = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk_in);
        check("rst_clk_out", 32'(clk_out), 32'h0);
        check("rst_cfg_pend", 32'(cfg_pend), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        rst   = 1'b0;
        edges = 0;

        // Default HALF=499: rise at 500, fall at 1000, all channels alike
        run_to(499);  check("t1_pre_rise", 32'(clk_out), 32'h0);
        run_to(500);  check("t1_rise", 32'(clk_out), 32'hF);
                      check("t1_tick", 32'(tick), TICK_ON ? 32'hF : 32'h0);
        run_to(501);  check("t1_tick_once", 32'(tick), 32'h0);
        run_to(999);  check("t1_pre_fall", 32'(clk_out), 32'hF);
        run_to(1000); check("t1_fall", 32'(clk_out), 32'h0);

        // ch1 HALF=3 mid half-period: pending until the 1500 toggle, then period 8
        run_to(1200); write_cfg(2'd1, 16'd3);
        check("t2_pend_set", 32'(cfg_pend), 32'h2);
        run_to(1499); check("t2_pend_hold", 32'(cfg_pend), 32'h2);
        run_to(1500); check("t2_rise", 32'(clk_out), 32'hF);
                      check("t2_pend_clr", 32'(cfg_pend), 32'h0);
        run_to(1503); check("t2_hi", 32'(clk_out), 32'hF);
        run_to(1504); check("t2_fall", 32'(clk_out), 32'hD);
        run_to(1508); check("t2_rise2", 32'(clk_out), 32'hF);

        // ch2 HALF=0 ; ch3 HALF=9 then HALF=4 (last write wins)
        run_to(1600); write_cfg(2'd2, 16'd0);
        run_to(1700); write_cfg(2'd3, 16'd9);
        run_to(1800); write_cfg(2'd3, 16'd4);
        check("t4_pend", 32'(cfg_pend), 32'hC);
        run_to(2000); check("t3_all_low", 32'(clk_out), 32'h0);
                      check("t3_pend_clr", 32'(cfg_pend), 32'h0);
        run_to(2001); check("t3_div2_hi", 32'(clk_out), 32'h4);
        run_to(2002); check("t3_div2_lo", 32'(clk_out), 32'h0);
        run_to(2004); check("t4_c3_lo", 32'(clk_out[3]), 32'h0);
        run_to(2005); check("t4_c3_rise", 32'(clk_out[3]), 32'h1);
        run_to(2009); check("t4_c3_hi", 32'(clk_out[3]), 32'h1);
        run_to(2010); check("t4_c3_fall", 32'(clk_out[3]), 32'h0);

        // ch1: write coinciding with a toggle, with and without a prior pend
        run_to(2099); write_cfg(2'd1, 16'd1);
        check("t2b_same_edge_nopend", 32'(cfg_pend[1]), 32'h1);
        run_to(2106); write_cfg(2'd1, 16'd5);
        write_cfg(2'd1, 16'd2);
        check("t2b_same_edge_pend", 32'(cfg_pend[1]), 32'h1);
        run_to(2113); check("t2b_pend_hold", 32'(cfg_pend[1]), 32'h1);
        run_to(2114); check("t2b_pend_apply", 32'(cfg_pend[1]), 32'h0);

        // ch0 disabled while high, written while disabled, then re-enabled
        run_to(2600); ch_en = 4'b1110;
        run_to(2601); check("t5_forced_low", 32'(clk_out[0]), 32'h0);
                      check("t5_no_tick", 32'(tick[0]), 32'h0);
        run_to(2603); write_cfg(2'd0, 16'd2);
        check("t5_pend_dis", 32'(cfg_pend[0]), 32'h1);
        run_to(2605); check("t5_pend_landed", 32'(cfg_pend[0]), 32'h0);
        run_to(2610); ch_en = 4'hF;
        run_to(2612); check("t5_pre_rise", 32'(clk_out[0]), 32'h0);
        run_to(2613); check("t5_rise", 32'(clk_out[0]), 32'h1);
                      check("t5_tick", 32'(tick[0]), 32'(TICK_ON));

        // Async reset mid-period with a pending write that must be lost
        run_to(2696); write_cfg(2'd3, 16'd7);
        check("t6_pend_before", 32'(cfg_pend[3]), 32'h1);
        run_to(2698);
        #2 rst = 1'b1;
        #1;
        check("t6_async_clk_out", 32'(clk_out), 32'h0);
        check("t6_async_pend", 32'(cfg_pend), 32'h0);
        check("t6_async_tick", 32'(tick), 32'h0);
        repeat (2) @(negedge clk_in);
        rst   = 1'b0;
        edges = 0;
        run_to(499);  check("t6_post_pre_rise", 32'(clk_out), 32'h0);
        run_to(500);  check("t6_post_rise", 32'(clk_out), 32'hF);
        run_to(510);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
